// File: rtl/pll_rst_pkg.sv
// -----------------------------------------------------------------------------
// pll_rst_pkg
// Shared types and default constants for the PLL reset sequencer.
//   state_t          : sequencer states (WAIT_LOCK, HOLD, RUN)
//   HOLD_CYCLES_DEF  : default reset hold time after lock qualifies (clk_sys cycles)
//   DIV_VDP_DEF      : default clk_sys cycles per ce_21m pulse
//   DIV_CPU_DEF      : default clk_sys cycles per ce_3m58 pulse
//   CNT_W            : width of the lock-loss counter
//   HOLD_W           : width of the hold counter (covers HOLD_CYCLES up to 65535)
// -----------------------------------------------------------------------------
package pll_rst_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RUN       = 2'd2
    } state_t;

    localparam int HOLD_CYCLES_DEF = 1024;
    localparam int DIV_VDP_DEF     = 4;
    localparam int DIV_CPU_DEF     = 24;
    localparam int CNT_W           = 8;
    localparam int HOLD_W          = 16;

endpackage

// File: rtl/sync_ff2.sv
// -----------------------------------------------------------------------------
// sync_ff2
// Two-flop synchronizer for a single asynchronous level signal.
//   clk   : destination clock
//   rst_n : asynchronous active-low clear, both flops go to 0
//   d     : asynchronous input
//   q     : synchronized output, two destination-clock cycles of latency
// -----------------------------------------------------------------------------
module sync_ff2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_rst_seq.sv
// -----------------------------------------------------------------------------
// pll_rst_seq
// Core reset sequencer and clock-enable generator running from the PLL clock.
// Holds the core in reset until the PLL lock has been stable for HOLD_CYCLES,
// then releases reset and produces the VDP and CPU clock enables.
//
// Parameters:
//   HOLD_CYCLES : clk_sys cycles reset is held after lock qualifies (2..65535)
//   DIV_VDP     : clk_sys cycles per ce_21m pulse
//   DIV_CPU     : clk_sys cycles per ce_3m58 pulse
// Ports:
//   clk_sys       in  : 85.90908 MHz PLL clock
//   rst_n         in  : asynchronous active-low reset
//   pll_locked    in  : PLL lock flag, asynchronous to clk_sys
//   soft_rst      in  : single-cycle core reset request, honoured only in RUN
//   sys_reset     out : active-high core reset
//   ready         out : high while in RUN
//   ce_21m        out : one-cycle VDP clock enable
//   ce_3m58       out : one-cycle CPU clock enable
//   lock_lost_cnt out : saturating count of lock losses seen in RUN
// Build option:
//   PLL_RST_SEQ_LOSS_CNT_EN : when defined, the lock-loss counter is built;
//                             otherwise lock_lost_cnt is tied to 0.
// -----------------------------------------------------------------------------
module pll_rst_seq
    import pll_rst_pkg::*;
#(
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
    parameter int DIV_VDP     = DIV_VDP_DEF,
    parameter int DIV_CPU     = DIV_CPU_DEF
) (
    input  logic             clk_sys,
    input  logic             rst_n,
    input  logic             pll_locked,
    input  logic             soft_rst,
    output logic             sys_reset,
    output logic             ready,
    output logic             ce_21m,
    output logic             ce_3m58,
    output logic [CNT_W-1:0] lock_lost_cnt
);

    localparam int VDP_W = (DIV_VDP > 1) ? $clog2(DIV_VDP) : 1;
    localparam int CPU_W = (DIV_CPU > 1) ? $clog2(DIV_CPU) : 1;

    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [VDP_W-1:0]  VDP_LAST  = VDP_W'(DIV_VDP - 1);
    localparam logic [CPU_W-1:0]  CPU_LAST  = CPU_W'(DIV_CPU - 1);

    state_t            state, state_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_nxt;
    logic [VDP_W-1:0]  div_vdp;
    logic [CPU_W-1:0]  div_cpu;
    logic              locked_s;

    sync_ff2 u_sync (
        .clk   (clk_sys),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (locked_s)
    );

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state    <= WAIT_LOCK;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_nxt;
        end
    end

    // Lock loss is tested before soft_rst in RUN so a coincident request
    // still ends in WAIT_LOCK and is counted as a loss.
    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        sys_reset = 1'b1;
        ready     = 1'b0;
        unique case (state)
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_nxt = HOLD;
                    hold_nxt  = HOLD_LOAD;
                end
            end
            HOLD: begin
                if (!locked_s) begin
                    state_nxt = WAIT_LOCK;
                    hold_nxt  = '0;
                end else if (hold_cnt == '0) begin
                    state_nxt = RUN;
                end else begin
                    hold_nxt = hold_cnt - 1'b1;
                end
            end
            RUN: begin
                sys_reset = 1'b0;
                ready     = 1'b1;
                if (!locked_s) begin
                    state_nxt = WAIT_LOCK;
                end else if (soft_rst) begin
                    state_nxt = HOLD;
                    hold_nxt  = HOLD_LOAD;
                end
            end
            default: begin
                state_nxt = WAIT_LOCK;
            end
        endcase
    end

    // Dividers are held at 0 outside RUN, so every RUN entry starts a fresh
    // phase and the first enable lands in the DIV-th RUN cycle.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            div_vdp <= '0;
            div_cpu <= '0;
        end else if (state == RUN) begin
            div_vdp <= (div_vdp == VDP_LAST) ? '0 : div_vdp + 1'b1;
            div_cpu <= (div_cpu == CPU_LAST) ? '0 : div_cpu + 1'b1;
        end else begin
            div_vdp <= '0;
            div_cpu <= '0;
        end
    end

    assign ce_21m  = (state == RUN) && (div_vdp == VDP_LAST);
    assign ce_3m58 = (state == RUN) && (div_cpu == CPU_LAST);

`ifdef PLL_RST_SEQ_LOSS_CNT_EN
    logic             lost_evt;
    logic [CNT_W-1:0] lost_cnt;

    assign lost_evt = (state == RUN) && !locked_s;

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            lost_cnt <= '0;
        end else if (lost_evt && (lost_cnt != '1)) begin
            lost_cnt <= lost_cnt + 1'b1;
        end
    end

    assign lock_lost_cnt = lost_cnt;
`else
    assign lock_lost_cnt = '0;
`endif

endmodule

// File: doc/pll_rst_seq.md
PLL_RST_SEQ -- requirements
Module: pll_rst_seq

Interface
REQ-001 SHALL provide parameter HOLD_CYCLES, default 1024: clk_sys cycles reset is held after lock qualifies (legal 2..65535).
REQ-002 SHALL provide parameter DIV_VDP, default 4: clk_sys cycles per ce_21m pulse (85.90908 MHz / 4 = 21.47727 MHz).
REQ-003 SHALL provide parameter DIV_CPU, default 24: clk_sys cycles per ce_3m58 pulse (3.579545 MHz).
REQ-004 SHALL have port clk_sys, input, 1: single clock, the 85.90908 MHz PLL output.
REQ-005 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port pll_locked, input, 1: PLL lock flag, asynchronous to clk_sys.
REQ-007 SHALL have port soft_rst, input, 1: synchronous single-cycle core-reset request.
REQ-008 SHALL have port sys_reset, output, 1: active-high synchronous core reset.
REQ-009 SHALL have port ready, output, 1: high only in state RUN.
REQ-010 SHALL have port ce_21m, output, 1: one-cycle VDP clock enable.
REQ-011 SHALL have port ce_3m58, output, 1: one-cycle CPU clock enable.
REQ-012 SHALL have port lock_lost_cnt, output, 8: saturating count of lock losses while in RUN.

Function
REQ-013 SHALL pass pll_locked through a 2-flop synchronizer (locked_s); all decisions use locked_s, giving 2-cycle input latency.
REQ-014 SHALL implement states WAIT_LOCK, HOLD, RUN.
REQ-015 WAIT_LOCK: sys_reset=1, ready=0, enables 0; on locked_s=1 go to HOLD and load hold counter with HOLD_CYCLES-1.
REQ-016 HOLD: sys_reset=1; decrement each cycle; locked_s=0 returns to WAIT_LOCK (counter discarded); counter==0 goes to RUN.
REQ-017 RUN: sys_reset=0, ready=1; locked_s=0 goes to WAIT_LOCK, asserting sys_reset on the next edge; soft_rst=1 goes to HOLD with counter reloaded.
REQ-018 Simultaneous locked_s=0 and soft_rst=1 in RUN: lock loss wins (WAIT_LOCK, counted).
REQ-019 soft_rst SHALL be ignored outside RUN.
REQ-020 Divider counters SHALL be 0 on every RUN entry and run only in RUN; ce_21m high when div_vdp==DIV_VDP-1, ce_3m58 high when div_cpu==DIV_CPU-1; both wrap to 0.
REQ-021 First ce_21m SHALL occur in the DIV_VDP-th RUN cycle, first ce_3m58 in the DIV_CPU-th; coincident pulses every lcm(DIV_VDP,DIV_CPU) cycles are legal.
REQ-022 lock_lost_cnt SHALL increment on each RUN->WAIT_LOCK transition, saturate at 255, and clear only on rst_n.

Reset
REQ-023 rst_n=0 SHALL asynchronously force: state WAIT_LOCK, synchronizer flops 0, hold/divider counters 0, sys_reset=1, ready=0, ce_21m=0, ce_3m58=0, lock_lost_cnt=0.
REQ-024 Release of rst_n SHALL NOT release sys_reset before a complete WAIT_LOCK->HOLD->RUN sequence.

Configuration
REQ-025 Macro PLL_RST_SEQ_LOSS_CNT_EN SHALL compile in the lock-loss counter per REQ-022.
REQ-026 Without PLL_RST_SEQ_LOSS_CNT_EN, lock_lost_cnt SHALL be constant 0 and no counter register SHALL exist; all other behaviour is unchanged.

Structure
REQ-027 Package pll_rst_pkg SHALL hold the state enum type and default constants (HOLD_CYCLES, DIV_VDP, DIV_CPU defaults, counter width 8).
REQ-028 The synchronizer SHALL be sub-module sync_ff2 (2 flops, async active-low clear to 0); the FSM, counters and dividers stay in pll_rst_seq.

Verification (HOLD_CYCLES=16)
REQ-029 rst_n release, pll_locked=1 at cycle 0 -> sys_reset falls after 2+1+16 cycles (±1), ready rises on the same edge.
REQ-030 In RUN, sample 240 cycles -> exactly 60 ce_21m and 10 ce_3m58; first ce_21m in RUN cycle 4, first ce_3m58 in cycle 24.
REQ-031 pll_locked drops at HOLD count 5 -> back to WAIT_LOCK, lock_lost_cnt stays 0; relock -> full 16-cycle hold again.
REQ-032 300 lock losses during RUN -> lock_lost_cnt=255 (0 with macro undefined); sys_reset asserted within 3 cycles of each drop.
REQ-033 soft_rst pulse in RUN -> sys_reset=1 for 16 cycles, dividers restart from 0, lock_lost_cnt unchanged; soft_rst and lock drop in the same cycle -> WAIT_LOCK, count +1.
REQ-034 rst_n asserted mid-HOLD and mid-RUN -> all outputs at reset values asynchronously, without waiting for a clk_sys edge.
